spwm_gate_gen: RTL and testbench
================================

# spwm_gate_gen

Sample-consuming end of the SPWM chain: accepts 12-bit sine reference samples from a sine LUT stream and compares them against an internal symmetric triangle carrier. It drives one complementary half-bridge leg (high and low gate) with optional dead-time insertion. It requests a new sample at every carrier turning point (regular sampling). One instance is used per phase.

## Interface
- DATA_W, 12, sample and carrier width
- CARR_MAX, 1250, carrier peak count; carrier period = 2*CARR_MAX cycles
- DT_CYCLES, 8, dead-time length in clk_in cycles (1..255)
- clk_in  in  1  system clock
- rst  in  1  reset, synchronous and active-high
- en  in  1  leg enable; low forces both gates off
- sample_in  in  DATA_W  sine reference sample, unsigned
- sample_valid  in  1  sample_in qualifier; captured into the shadow register when high
- sample_req  out  1  one-cycle pulse at each carrier turning point (upstream advances its LUT index)
- carrier_out  out  DATA_W  current triangle count (debug/sync)
- pwm_raw  out  1  registered compare result (active_ref > carrier)
- gate_hi  out  1  high-side gate
- gate_lo  out  1  low-side gate

## Operation
- Carrier: up/down counter cnt in 0..CARR_MAX. Counts up after reset; reverses at CARR_MAX and at 0. Sequence: 0,1..CARR_MAX,CARR_MAX-1..1,0,...
- Turning point (tp): cycle where cnt==0 or cnt==CARR_MAX.
- Shadow: shadow <= sample_in whenever sample_valid.
- At tp: active_ref <= sample_valid ? sample_in : shadow (same-cycle bypass), and sample_req=1. No other cycle changes active_ref.
- Compare: pwm_raw <= en & (active_ref > cnt). ref=0 gives 0 % duty; ref>CARR_MAX gives 100 %. No clamping.
- Gate FSM states: IDLE (both 0), DT_UP (both 0, counting toward HI), HI (gate_hi=1), DT_DN (both 0, counting toward LO), LO (gate_lo=1).
  - en=0 in any state -> IDLE next cycle.
  - IDLE & en: pwm_raw ? DT_UP : DT_DN.
  - LO & pwm_raw -> DT_UP; HI & !pwm_raw -> DT_DN.
  - DT_UP: dt counter reaches DT_CYCLES-1 -> HI; if pwm_raw drops first -> LO immediately (the previously-on gate may return without dead time).
  - DT_DN: mirror (-> LO on expiry; pwm_raw rises first -> HI).
  - The dead-time counter clears on every DT_* entry.
- Invariant: gate_hi & gate_lo is never 1.

## Timing
- Reset values: cnt=0, direction up, shadow=0, active_ref=0, pwm_raw=0, FSM IDLE, gate_hi=0, gate_lo=0, sample_req=0, carrier_out=0.
- carrier_out = cnt (registered, zero added latency).
- pwm_raw reflects the compare of the cnt from one cycle earlier.
- sample_req is asserted in the tp cycle. active_ref takes effect on the pwm_raw edge in the following cycle.
- Outgoing gate deasserts 1 cycle after the pwm_raw change. Incoming gate asserts DT_CYCLES+1 cycles after the pwm_raw change.
- rst mid-period: everything returns to reset values next cycle. The carrier restarts at 0 upward and the first sample_req occurs in the first cycle after reset release (cnt==0).
- en deassert: both gates 0 one cycle later. The carrier and sampling keep running.

## Configuration
- SPWM_DEADTIME_EN defined: the dead-time FSM is used as above.
- SPWM_DEADTIME_EN undefined:
  - gate_hi <= en & pwm_raw and gate_lo <= en & !pwm_raw, both registered (1-cycle latency from pwm_raw).
  - DT_CYCLES is ignored; the FSM and counter are not instantiated.

## Structure
- Package spwm_pkg holds:
  - gate_state_t enum (IDLE, DT_UP, HI, DT_DN, LO)
  - default DATA_W
  - dead-time counter width constant DT_W=8
- Sub-module spwm_deadtime contains the gate FSM and dead-time counter (inputs pwm_raw, en; outputs gate_hi, gate_lo). It is instantiated only under SPWM_DEADTIME_EN.
- Carrier, shadow/active registers and the compare stay in the top module.

## Test plan
Use CARR_MAX=15, DT_CYCLES=3 unless noted.
- Reset, en=1, ref=8 constant: carrier period 30; pwm_raw high 15 of every 30 cycles; sample_req every 15 cycles, first in the cycle after reset release.
- Walk the pwm_raw 0->1 edge: gate_lo falls 1 cycle after the edge; gate_hi rises 4 cycles after the edge; both never high together.
- Glitch: ref changed so pwm_raw is high for only 2 cycles: FSM DT_UP -> LO; gate_hi never asserts; gate_lo off for 2 cycles.
- ref=0 -> gate_lo solid; ref=16 -> gate_hi solid after dead time. A new sample_valid arriving mid-period takes effect only at the next tp.
- en dropped mid-HI -> both gates 0 next cycle. Re-enable -> dead time of 3 cycles before either gate asserts. rst mid-period -> carrier_out=0 next cycle.
- With SPWM_DEADTIME_EN undefined and ref=8: gate_hi == pwm_raw delayed 1 cycle; gate_lo is its complement.

Source files
------------

// File: rtl/spwm_pkg.sv
// spwm_pkg: shared types and constants for the SPWM gate generator.
// Used by spwm_gate_gen and by spwm_deadtime when SPWM_DEADTIME_EN is defined.
package spwm_pkg;

    localparam int unsigned DEF_DATA_W = 12;
    localparam int unsigned DT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        DT_UP,
        HI,
        DT_DN,
        LO
    } gate_state_t;

endpackage

// File: rtl/spwm_deadtime.sv
// spwm_deadtime: complementary gate FSM with dead-time insertion.
// Compiled only when SPWM_DEADTIME_EN is defined.
`ifdef SPWM_DEADTIME_EN
module spwm_deadtime
    import spwm_pkg::*;
#(
    parameter int unsigned DT_CYCLES = 8
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic pwm_raw,
    output logic gate_hi,
    output logic gate_lo
);

    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DT_CYCLES - 1);

    gate_state_t     state_q, state_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = pwm_raw ? DT_UP : DT_DN;
            DT_UP: begin
                // A short pulse returns straight to the gate that was on.
                if (!pwm_raw)                 state_d = LO;
                else if (dt_cnt_q == DT_LAST) state_d = HI;
            end
            HI:    if (!pwm_raw) state_d = DT_DN;
            DT_DN: begin
                if (pwm_raw)                  state_d = HI;
                else if (dt_cnt_q == DT_LAST) state_d = LO;
            end
            LO:    if (pwm_raw) state_d = DT_UP;
            default: state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;

        dt_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == DT_UP) || (state_q == DT_DN)))
            dt_cnt_d = dt_cnt_q + 1'b1;

        gate_hi = (state_q == HI);
        gate_lo = (state_q == LO);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= IDLE;
            dt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end

endmodule
`endif

// File: rtl/spwm_gate_gen.sv
// spwm_gate_gen: triangle-carrier SPWM comparator driving one half-bridge leg.
// Define SPWM_DEADTIME_EN to insert dead time via spwm_deadtime; otherwise gates are plain registered.
module spwm_gate_gen
    import spwm_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CARR_MAX  = 1250,
    parameter int unsigned DT_CYCLES = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_req,
    output logic [DATA_W-1:0] carrier_out,
    output logic              pwm_raw,
    output logic              gate_hi,
    output logic              gate_lo
);

    localparam logic [DATA_W-1:0] PEAK = DATA_W'(CARR_MAX);

    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_ref_q, active_ref_d;
    logic              dir_up_q, dir_up_d;
    logic              pwm_raw_q, pwm_raw_d;
    logic              at_tp;

    always_comb begin
        at_tp    = (cnt_q == '0) || (cnt_q == PEAK);
        dir_up_d = dir_up_q;
        if (cnt_q == '0)        dir_up_d = 1'b1;
        else if (cnt_q == PEAK) dir_up_d = 1'b0;
        cnt_d = dir_up_d ? cnt_q + 1'b1 : cnt_q - 1'b1;

        shadow_d = sample_valid ? sample_in : shadow_q;

        // Same-cycle bypass so a sample arriving on the turning point is used at once.
        active_ref_d = active_ref_q;
        if (at_tp) active_ref_d = sample_valid ? sample_in : shadow_q;

        pwm_raw_d = en & (active_ref_q > cnt_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q        <= '0;
            dir_up_q     <= 1'b1;
            shadow_q     <= '0;
            active_ref_q <= '0;
            pwm_raw_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_up_q     <= dir_up_d;
            shadow_q     <= shadow_d;
            active_ref_q <= active_ref_d;
            pwm_raw_q    <= pwm_raw_d;
        end
    end

    assign sample_req  = at_tp & ~rst;
    assign carrier_out = cnt_q;
    assign pwm_raw     = pwm_raw_q;

`ifdef SPWM_DEADTIME_EN
    spwm_deadtime #(
        .DT_CYCLES (DT_CYCLES)
    ) u_deadtime (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .pwm_raw (pwm_raw_q),
        .gate_hi (gate_hi),
        .gate_lo (gate_lo)
    );
`else
    logic gate_hi_q, gate_hi_d;
    logic gate_lo_q, gate_lo_d;

    always_comb begin
        gate_hi_d = en & pwm_raw_q;
        gate_lo_d = en & ~pwm_raw_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi = gate_hi_q;
    assign gate_lo = gate_lo_q;
`endif

endmodule

// File: tb/tb_spwm_gate_gen.sv
// tb_spwm_gate_gen: scoreboard bench for spwm_gate_gen with CARR_MAX=15, DT_CYCLES=3.
// Gate expectations follow SPWM_DEADTIME_EN when it is defined.
module tb_spwm_gate_gen;

    localparam int unsigned DW   = 12;
    localparam int          CMAX = 15;
    localparam int          DTC  = 3;
`ifdef SPWM_DEADTIME_EN
    localparam int REEN_GAP = DTC;
`else
    localparam int REEN_GAP = 0;
`endif

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_req;
    logic [DW-1:0] carrier_out;
    logic          pwm_raw;
    logic          gate_hi;
    logic          gate_lo;

    spwm_gate_gen #(
        .DATA_W    (DW),
        .CARR_MAX  (CMAX),
        .DT_CYCLES (DTC)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_req   (sample_req),
        .carrier_out  (carrier_out),
        .pwm_raw      (pwm_raw),
        .gate_hi      (gate_hi),
        .gate_lo      (gate_lo)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [DW-1:0] carrier;
        logic          req;
        logic          pwm;
        logic          ghi;
        logic          glo;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (cycle index since reset release, sampled refs, gate tracker)
    int            m_k;
    logic [DW-1:0] m_shadow;
    logic [DW-1:0] m_aref;
    logic          m_pwm;
    logic          m_side;
    int            m_run;
    logic          obs_pwm, obs_req, obs_ghi, obs_glo;

    function automatic int tri_at(input int k);
        int m;
        m = k % (2 * CMAX);
        return (m <= CMAX) ? m : (2 * CMAX - m);
    endfunction

    task automatic step_cycle(input logic en_v, input logic vld_v, input logic [DW-1:0] s_v);
        exp_t e;
        exp_t got;
        int   c;
        en           = en_v;
        sample_valid = vld_v;
        sample_in    = s_v;
        c         = tri_at(m_k);
        e.carrier = DW'(tri_at(m_k + 1));
        e.req     = (tri_at(m_k + 1) == 0) || (tri_at(m_k + 1) == CMAX);
        e.pwm     = en_v && (int'(m_aref) > c);
`ifdef SPWM_DEADTIME_EN
        if (!en_v) m_run = 0;
        else if (m_run == 0) begin
            m_side = m_pwm;
            m_run  = 1;
        end else if (m_pwm == m_side) begin
            if (m_run <= DTC) m_run++;
        end else if (m_run <= DTC) begin
            m_side = m_pwm;
            m_run  = DTC + 1;
        end else begin
            m_side = m_pwm;
            m_run  = 1;
        end
        e.ghi = en_v && (m_run > DTC) && m_side;
        e.glo = en_v && (m_run > DTC) && !m_side;
`else
        e.ghi = en_v & m_pwm;
        e.glo = en_v & ~m_pwm;
`endif
        if (c == 0 || c == CMAX) m_aref = vld_v ? s_v : m_shadow;
        if (vld_v) m_shadow = s_v;
        sb.push_back(e);

        @(negedge clk_in);
        got = sb.pop_front();
        n_tests++;
        if (carrier_out !== got.carrier) begin
            n_fail++;
            $display("FAIL carrier k=%0d: got %0d expected %0d", m_k + 1, carrier_out, got.carrier);
        end
        n_tests++;
        if (sample_req !== got.req) begin
            n_fail++;
            $display("FAIL sample_req k=%0d: got %b expected %b", m_k + 1, sample_req, got.req);
        end
        n_tests++;
        if (pwm_raw !== got.pwm) begin
            n_fail++;
            $display("FAIL pwm_raw k=%0d: got %b expected %b", m_k + 1, pwm_raw, got.pwm);
        end
        n_tests++;
        if (gate_hi !== got.ghi) begin
            n_fail++;
            $display("FAIL gate_hi k=%0d: got %b expected %b", m_k + 1, gate_hi, got.ghi);
        end
        n_tests++;
        if (gate_lo !== got.glo) begin
            n_fail++;
            $display("FAIL gate_lo k=%0d: got %b expected %b", m_k + 1, gate_lo, got.glo);
        end
        n_tests++;
        if ((gate_hi & gate_lo) !== 1'b0) begin
            n_fail++;
            $display("FAIL shoot_through k=%0d: got hi=%b lo=%b expected not both 1", m_k + 1, gate_hi, gate_lo);
        end
        m_k++;
        m_pwm   = got.pwm;
        obs_pwm = pwm_raw;
        obs_req = sample_req;
        obs_ghi = gate_hi;
        obs_glo = gate_lo;
    endtask

    task automatic apply_reset(input int n);
        rst          = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        repeat (n) begin
            @(negedge clk_in);
            n_tests++;
            if ({carrier_out, sample_req, pwm_raw, gate_hi, gate_lo} !== '0) begin
                n_fail++;
                $display("FAIL reset_values: got carrier=%0d req=%b pwm=%b hi=%b lo=%b expected all 0",
                         carrier_out, sample_req, pwm_raw, gate_hi, gate_lo);
            end
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (carrier_out !== '0 || sample_req !== 1'b1) begin
            n_fail++;
            $display("FAIL first_req_after_reset: got carrier=%0d req=%b expected carrier=0 req=1",
                     carrier_out, sample_req);
        end
        m_k = 0; m_shadow = '0; m_aref = '0; m_pwm = 1'b0; m_side = 1'b0; m_run = 0;
    endtask

    task automatic test_reset();
        apply_reset(3);
    endtask

    task automatic test_carrier_ref8();
        int hi_cnt, req_cnt;
        apply_reset(2);
        repeat (30) step_cycle(1'b1, 1'b1, DW'(8));
        hi_cnt = 0; req_cnt = 0;
        repeat (30) begin
            step_cycle(1'b1, 1'b1, DW'(8));
            hi_cnt  += int'(obs_pwm);
            req_cnt += int'(obs_req);
        end
        n_tests++;
        if (hi_cnt != 15) begin
            n_fail++;
            $display("FAIL duty_ref8: got %0d high cycles expected 15", hi_cnt);
        end
        n_tests++;
        if (req_cnt != 2) begin
            n_fail++;
            $display("FAIL req_rate: got %0d requests expected 2", req_cnt);
        end
    endtask

    task automatic test_glitch();
        int hi_cnt, ghi_cnt;
        apply_reset(2);
        repeat (15) step_cycle(1'b1, 1'b1, DW'(0));
        step_cycle(1'b1, 1'b1, DW'(2));
        hi_cnt = 0; ghi_cnt = 0;
        repeat (14) begin
            step_cycle(1'b1, 1'b0, DW'(0));
            hi_cnt += int'(obs_pwm);
        end
        repeat (16) begin
            step_cycle(1'b1, 1'b1, DW'(1));
            hi_cnt  += int'(obs_pwm);
            ghi_cnt += int'(obs_ghi);
        end
        n_tests++;
        if (hi_cnt != 2) begin
            n_fail++;
            $display("FAIL glitch_width: got %0d high cycles expected 2", hi_cnt);
        end
`ifdef SPWM_DEADTIME_EN
        n_tests++;
        if (ghi_cnt != 0) begin
            n_fail++;
            $display("FAIL glitch_gate_hi: got %0d cycles expected 0", ghi_cnt);
        end
`endif
    endtask

    task automatic test_extremes_mid_sample();
        apply_reset(2);
        repeat (31) step_cycle(1'b1, 1'b1, DW'(0));
        n_tests++;
        if (obs_glo !== 1'b1 || obs_ghi !== 1'b0) begin
            n_fail++;
            $display("FAIL ref0_solid_lo: got hi=%b lo=%b expected hi=0 lo=1", obs_ghi, obs_glo);
        end
        repeat (40) step_cycle(1'b1, 1'b1, DW'(16));
        n_tests++;
        if (obs_ghi !== 1'b1 || obs_glo !== 1'b0) begin
            n_fail++;
            $display("FAIL ref16_solid_hi: got hi=%b lo=%b expected hi=1 lo=0", obs_ghi, obs_glo);
        end
        // one-cycle valid mid-slope; only the next turning point may pick it up
        repeat (5) step_cycle(1'b1, 1'b0, DW'(0));
        step_cycle(1'b1, 1'b1, DW'(4));
        repeat (4) step_cycle(1'b1, 1'b0, DW'(9));
        n_tests++;
        if (obs_pwm !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sample_held: got pwm=%b expected 1", obs_pwm);
        end
        repeat (40) step_cycle(1'b1, 1'b0, DW'(9));
    endtask

    task automatic test_enable();
        int gap;
        apply_reset(2);
        repeat (20) step_cycle(1'b1, 1'b1, DW'(16));
        step_cycle(1'b0, 1'b1, DW'(16));
        n_tests++;
        if (obs_ghi !== 1'b0 || obs_glo !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop: got hi=%b lo=%b expected both 0", obs_ghi, obs_glo);
        end
        repeat (20) step_cycle(1'b0, 1'b1, DW'(0));
        gap = 0;
        step_cycle(1'b1, 1'b1, DW'(0));
        while (gap < 10 && obs_ghi == 1'b0 && obs_glo == 1'b0) begin
            gap++;
            step_cycle(1'b1, 1'b1, DW'(0));
        end
        n_tests++;
        if (gap != REEN_GAP) begin
            n_fail++;
            $display("FAIL reenable_gap: got %0d off cycles expected %0d", gap, REEN_GAP);
        end
        repeat (10) step_cycle(1'b1, 1'b1, DW'(0));
    endtask

    task automatic test_rst_mid();
        apply_reset(2);
        repeat (20) step_cycle(1'b1, 1'b1, DW'(8));
        apply_reset(1);
        repeat (40) step_cycle(1'b1, 1'b1, DW'(8));
    endtask

    task automatic test_back_to_back();
        apply_reset(2);
        for (int i = 0; i < 300; i++) begin
            step_cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                       DW'($urandom_range(0, 18)));
        end
    endtask

    initial begin
        test_reset();
        test_carrier_ref8();
        test_glitch();
        test_extremes_mid_sample();
        test_enable();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
